// File: rtl/div_pkg.sv
// Shared definitions for the RV32M iterative divider: func3 encodings,
// FSM state encoding and small operand helpers.
package div_pkg;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_END  = 2'd2
    } state_t;

    function automatic logic [31:0] negate(input logic [31:0] value);
        return ~value + 32'd1;
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == INST_DIV) || (op == INST_REM);
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return (op == INST_REM) || (op == INST_REMU);
    endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU: one quotient bit per
// cycle, divide-by-zero and signed overflow resolved without iteration.
module div
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic [2:0]  op_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        ready_o,
    output logic [31:0] result_o,
    output logic [4:0]  rd_addr_o
);

    state_t      state;
    logic [4:0]  count;
    logic [31:0] rem;
    logic [31:0] quot;
    logic [31:0] divisor;
    logic [2:0]  op;
    logic [4:0]  rd_addr_q;
    logic        neg_quot;
    logic        neg_rem;

    logic        in_signed;
    logic [31:0] abs_op1;
    logic [31:0] abs_op2;
    logic        div_zero;
    logic        overflow;
    logic [31:0] special_quot;
    logic [31:0] special_rem;
    logic [31:0] special_res;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic        trial_ok;
    logic [31:0] rem_nxt;
    logic [31:0] quot_nxt;
    logic [31:0] raw_res;
    logic        res_neg;
    logic [31:0] final_res;

    always_comb begin
        in_signed    = op_is_signed(op_i);
        abs_op1      = (in_signed && op1_i[31]) ? negate(op1_i) : op1_i;
        abs_op2      = (in_signed && op2_i[31]) ? negate(op2_i) : op2_i;
        div_zero     = (op2_i == 32'd0);
        overflow     = in_signed && (op1_i == 32'h8000_0000) && (op2_i == 32'hFFFF_FFFF);
        // Special results are already final, so they bypass the sign fix-up.
        special_quot = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
        special_rem  = div_zero ? op1_i : 32'd0;
        special_res  = op_is_rem(op_i) ? special_rem : special_quot;

        // The remainder stays below the divisor, so a 33-bit trial cannot
        // overflow and bit 32 alone flags a negative difference.
        shifted      = {rem, quot[31]};
        trial        = shifted - {1'b0, divisor};
        trial_ok     = ~trial[32];
        rem_nxt      = trial_ok ? trial[31:0] : shifted[31:0];
        quot_nxt     = {quot[30:0], trial_ok};

        raw_res      = op_is_rem(op) ? rem_nxt : quot_nxt;
        res_neg      = op_is_signed(op) && (op_is_rem(op) ? neg_rem : neg_quot);
        final_res    = res_neg ? negate(raw_res) : raw_res;
    end

    assign busy_o = (state != S_IDLE);

    // NOTE: all state updates below use non-blocking assignments so every
    // register samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            count     <= 5'd0;
            rem       <= 32'd0;
            quot      <= 32'd0;
            divisor   <= 32'd0;
            op        <= 3'd0;
            rd_addr_q <= 5'd0;
            neg_quot  <= 1'b0;
            neg_rem   <= 1'b0;
            ready_o   <= 1'b0;
            result_o  <= 32'd0;
            rd_addr_o <= 5'd0;
        end else if (flush_i) begin
            state   <= S_IDLE;
            ready_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready_o <= 1'b0;
                    if (start_i) begin
                        op        <= op_i;
                        rd_addr_q <= rd_addr_i;
                        neg_quot  <= in_signed && (op1_i[31] ^ op2_i[31]);
                        neg_rem   <= in_signed && op1_i[31];
                        divisor   <= abs_op2;
                        count     <= 5'd0;
                        if (div_zero || overflow) begin
                            quot      <= special_quot;
                            rem       <= special_rem;
                            result_o  <= special_res;
                            rd_addr_o <= rd_addr_i;
                            ready_o   <= 1'b1;
                            state     <= S_END;
                        end else begin
                            quot  <= abs_op1;
                            rem   <= 32'd0;
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    quot  <= quot_nxt;
                    rem   <= rem_nxt;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        result_o  <= final_res;
                        rd_addr_o <= rd_addr_q;
                        ready_o   <= 1'b1;
                        state     <= S_END;
                    end
                end
                S_END: begin
                    ready_o <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    ready_o <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed bench for the iterative divider: latency, signed fix-up, special
// cases, flush, ignored start and asynchronous reset.
module tb_div;

    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [2:0]  op_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        busy_o;
    logic        ready_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;

    int checks = 0;
    int errors = 0;
    int tcyc   = 0;

    div dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .op1_i     (op1_i),
        .op2_i     (op2_i),
        .op_i      (op_i),
        .rd_addr_i (rd_addr_i),
        .flush_i   (flush_i),
        .busy_o    (busy_o),
        .ready_o   (ready_o),
        .result_o  (result_o),
        .rd_addr_o (rd_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a request in the current cycle (t); start stays high until step().
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        start_i   = 1'b1;
        flush_i   = 1'b0;
        op_i      = op;
        op1_i     = a;
        op2_i     = b;
        rd_addr_i = rd;
        tcyc      = 0;
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_at_issue busy=%b ready=%b required 0 0", busy_o, ready_o);
        end
    endtask

    task automatic step();
        @(negedge clk);
        start_i = 1'b0;
        flush_i = 1'b0;
        tcyc++;
    endtask

    task automatic wait_done(input int exp_lat, input logic [31:0] exp_res,
                             input logic [4:0] exp_rd, input string name);
        bit busy_ok;
        int seen;
        busy_ok = 1'b1;
        seen    = -1;
        while (tcyc < 60) begin
            step();
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            if (ready_o === 1'b1) begin
                seen = tcyc;
                break;
            end
        end
        checks++;
        if (seen != exp_lat) begin
            errors++;
            $display("FAIL %s_latency ready at cycle %0d required %0d", name, seen, exp_lat);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL %s_busy busy dropped before ready, required high through END", name);
        end
        checks++;
        if (result_o !== exp_res) begin
            errors++;
            $display("FAIL %s_result got %h required %h", name, result_o, exp_res);
        end
        checks++;
        if (rd_addr_o !== exp_rd) begin
            errors++;
            $display("FAIL %s_rd got %0d required %0d", name, rd_addr_o, exp_rd);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start_i   = 1'b0;
        flush_i   = 1'b0;
        op_i      = 3'd0;
        op1_i     = 32'd0;
        op2_i     = 32'd0;
        rd_addr_i = 5'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl busy=%b ready=%b required 0 0", busy_o, ready_o);
        end
        checks++;
        if (result_o !== 32'd0 || rd_addr_o !== 5'd0) begin
            errors++;
            $display("FAIL reset_data result=%h rd=%0d required 0 0", result_o, rd_addr_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release busy=%b ready=%b required 0 0", busy_o, ready_o);
        end
    endtask

    task automatic test_unsigned();
        issue(OP_DIVU, 32'd100, 32'd7, 5'd5);
        wait_done(33, 32'd14, 5'd5, "divu_100_7");
        issue(OP_REMU, 32'd100, 32'd7, 5'd6);
        wait_done(33, 32'd2, 5'd6, "remu_100_7");
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10);
        wait_done(33, 32'd1, 5'd10, "divu_max_max");
    endtask

    task automatic test_signed();
        issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd11);
        wait_done(33, 32'hFFFF_FFFF, 5'd11, "rem_m7_2");
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd12);
        wait_done(33, 32'hFFFF_FFFD, 5'd12, "div_m7_2");
        issue(OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd13);
        wait_done(33, 32'hFFFF_FFF2, 5'd13, "div_100_m7");
        issue(OP_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd14);
        wait_done(33, 32'hFFFF_FFFE, 5'd14, "rem_m100_m7");
    endtask

    task automatic test_div_zero();
        issue(OP_DIVU, 32'h0000_1234, 32'd0, 5'd15);
        wait_done(1, 32'hFFFF_FFFF, 5'd15, "divu_zero");
        issue(OP_REMU, 32'h0000_1234, 32'd0, 5'd16);
        wait_done(1, 32'h0000_1234, 5'd16, "remu_zero");
        issue(OP_REM, 32'hFFFF_FFFB, 32'd0, 5'd17);
        wait_done(1, 32'hFFFF_FFFB, 5'd17, "rem_neg_zero");
        issue(OP_DIV, 32'hFFFF_FFFB, 32'd0, 5'd18);
        wait_done(1, 32'hFFFF_FFFF, 5'd18, "div_neg_zero");
    endtask

    task automatic test_overflow();
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19);
        wait_done(1, 32'h8000_0000, 5'd19, "div_ovf");
        issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20);
        wait_done(1, 32'd0, 5'd20, "rem_ovf");
    endtask

    // Each issue() lands in the IDLE cycle right after the previous END.
    task automatic test_back_to_back();
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 5'd1);
        wait_done(33, 32'h0FFF_FFFF, 5'd1, "b2b_divu");
        issue(OP_REMU, 32'hFFFF_FFFF, 32'h10, 5'd2);
        wait_done(33, 32'h0000_000F, 5'd2, "b2b_remu");
        issue(OP_DIV, 32'd5, 32'd0, 5'd3);
        wait_done(1, 32'hFFFF_FFFF, 5'd3, "b2b_div_zero");
        issue(OP_REM, 32'd5, 32'd0, 5'd4);
        wait_done(1, 32'd5, 5'd4, "b2b_rem_zero");
        issue(OP_DIV, 32'h8000_0000, 32'd2, 5'd8);
        wait_done(33, 32'hC000_0000, 5'd8, "b2b_div_min_2");
    endtask

    task automatic test_flush();
        int ready_cnt;
        ready_cnt = 0;
        issue(OP_DIVU, 32'd1000, 32'd3, 5'd7);
        for (int i = 1; i <= 10; i++) begin
            step();
            if (ready_o === 1'b1) ready_cnt++;
        end
        flush_i = 1'b1;
        issue(OP_DIVU, 32'd200, 32'd9, 5'd12);
        checks++;
        if (ready_cnt != 0) begin
            errors++;
            $display("FAIL flush_no_ready saw %0d ready pulses required 0", ready_cnt);
        end
        checks++;
        if (result_o !== 32'hC000_0000 || rd_addr_o !== 5'd8) begin
            errors++;
            $display("FAIL flush_hold result=%h rd=%0d required c0000000 8", result_o, rd_addr_o);
        end
        wait_done(33, 32'd22, 5'd12, "after_flush");
    endtask

    task automatic test_flush_with_start();
        bit quiet;
        @(negedge clk);
        start_i   = 1'b1;
        flush_i   = 1'b1;
        op_i      = OP_DIVU;
        op1_i     = 32'd9;
        op2_i     = 32'd3;
        rd_addr_i = 5'd3;
        quiet     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (busy_o !== 1'b0 || ready_o !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet || result_o !== 32'd22) begin
            errors++;
            $display("FAIL flush_start_dropped busy=%b ready=%b result=%h required 0 0 00000016",
                     busy_o, ready_o, result_o);
        end
    endtask

    task automatic test_ignored_start();
        issue(OP_DIVU, 32'd100, 32'd7, 5'd5);
        repeat (5) step();
        start_i   = 1'b1;
        op_i      = OP_DIV;
        op1_i     = 32'd50;
        op2_i     = 32'd3;
        rd_addr_i = 5'd9;
        wait_done(33, 32'd14, 5'd5, "ignored_start");
    endtask

    task automatic test_reset_mid_op();
        bit quiet;
        issue(OP_DIVU, 32'd1000, 32'd3, 5'd21);
        repeat (20) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ctrl busy=%b ready=%b required 0 0", busy_o, ready_o);
        end
        checks++;
        if (result_o !== 32'd0 || rd_addr_o !== 5'd0) begin
            errors++;
            $display("FAIL mid_reset_data result=%h rd=%0d required 0 0", result_o, rd_addr_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ready_o !== 1'b0 || busy_o !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL mid_reset_quiet busy or ready seen after reset, required none");
        end
        issue(OP_DIVU, 32'd100, 32'd7, 5'd5);
        wait_done(33, 32'd14, 5'd5, "after_reset");
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_flush_with_start();
        test_ignored_start();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
